// File: rtl/zeroskip_pkg.sv
// Shared types and constants for the MAC1024 zero-skip feed path.
package zeroskip_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } zs_sched_state_t;

  // Encoder group_nz_sel values: quarter is 8:32, half is 8:16.
  localparam logic ZS_SEL_QUAR = 1'b0;
  localparam logic ZS_SEL_HALF = 1'b1;

endpackage

// File: rtl/zs_credit_cnt.sv
// Saturating credit counter for the downstream output buffer.
// Starts full, drops on consume, rises on return, never exceeds CREDITS.
module zs_credit_cnt #(
  parameter int unsigned CREDITS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic consume_i,
  input  logic return_i,
  output logic avail_o
);

  localparam int unsigned CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] FULL = CW'(CREDITS);

  logic [CW-1:0] count_q, count_d;

  // A simultaneous consume and return cancel out; returns beyond full are dropped.
  always_comb begin
    count_d = count_q;
    if (consume_i && !return_i && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end else if (return_i && !consume_i && (count_q != FULL)) begin
      count_d = count_q + CW'(1);
    end
  end

  // Counter register, refilled to full on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= FULL;
    end else begin
      count_q <= count_d;
    end
  end

  assign avail_o = (count_q != '0);

endmodule

// File: rtl/zeroskip_feed_sched.sv
// Feed scheduler for the MAC1024 zero-skip encoder.
// Accepts tile commands, issues one SRAM beat read per cycle under credit
// control, forwards returning data to the encoder, and reports tile completion
// by counting encoder output beats.
// Optional build macro ZS_SCHED_PERF_EN adds busy/stall performance counters.
module zeroskip_feed_sched
  import zeroskip_pkg::*;
#(
  parameter int unsigned M       = 32,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned LEN_W   = 10,
  parameter int unsigned RD_LAT  = 2,
  parameter int unsigned CREDITS = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_vld_i,
  output logic                  cmd_rdy_o,
  input  logic [ADDR_W-1:0]     cmd_addr_i,
  input  logic [LEN_W-1:0]      cmd_len_i,
  input  logic                  cmd_sel_i,
  output logic                  mem_rd_en_o,
  output logic [ADDR_W-1:0]     mem_rd_addr_o,
  input  logic [2*M*DATA_W-1:0] mem_act_rdata_i,
  input  logic [2*M*M-1:0]      mem_znz_rdata_i,
  output logic                  group_nz_sel_o,
  output logic [2*M*DATA_W-1:0] act_dout_o,
  output logic [2*M*M-1:0]      znz_dout_o,
  output logic                  act_vld_o,
  output logic                  znz_vld_o,
  input  logic                  act_rdy_i,
  input  logic                  znz_rdy_i,
  input  logic                  enc_vld_i,
  input  logic                  credit_ret_i,
  output logic                  done_o,
  output logic                  err_o
`ifdef ZS_SCHED_PERF_EN
  ,
  output logic [CNT_W-1:0]      perf_busy_cnt_o,
  output logic [CNT_W-1:0]      perf_stall_cnt_o
`endif
);

  zs_sched_state_t   state_q, state_d;
  logic              init_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [LEN_W-1:0]  exp_q, exp_d;
  logic [LEN_W-1:0]  enc_cnt_q, enc_cnt_d;
  logic              sel_q, sel_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [RD_LAT-1:0] vld_pipe_q, vld_pipe_d;

  logic cmd_fire;
  logic need_credit;
  logic credit_avail;
  logic issue;
  logic consume;
  logic ret_vld;

  zs_credit_cnt #(
    .CREDITS (CREDITS)
  ) u_credit (
    .clk       (clk),
    .rst_n     (rst_n),
    .consume_i (consume),
    .return_i  (credit_ret_i),
    .avail_o   (credit_avail)
  );

  assign cmd_rdy_o   = init_q && (state_q == IDLE);
  assign cmd_fire    = cmd_vld_i && cmd_rdy_o;
  // In quarter mode two input beats fold into one encoder output, so only even beats need a slot.
  assign need_credit = (sel_q == ZS_SEL_HALF) || !beat_q[0];

  // Next-state, issue decision and tile bookkeeping.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    beat_d     = beat_q;
    exp_d      = exp_q;
    enc_cnt_d  = enc_cnt_q;
    sel_d      = sel_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    issue      = 1'b0;
    consume    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          if ((cmd_sel_i == ZS_SEL_QUAR) && cmd_len_i[0]) begin
            err_d = 1'b1;
          end else begin
            sel_d     = cmd_sel_i;
            addr_d    = cmd_addr_i;
            len_d     = cmd_len_i;
            beat_d    = '0;
            enc_cnt_d = '0;
            exp_d     = (cmd_sel_i == ZS_SEL_HALF) ? cmd_len_i : (cmd_len_i >> 1);
            if (cmd_len_i == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = ISSUE;
            end
          end
        end
      end
      ISSUE: begin
        if (enc_vld_i) begin
          enc_cnt_d = enc_cnt_q + LEN_W'(1);
        end
        if (act_rdy_i && znz_rdy_i && (beat_q < len_q) && (!need_credit || credit_avail)) begin
          issue   = 1'b1;
          consume = need_credit;
          addr_d  = addr_q + ADDR_W'(1);
          beat_d  = beat_q + LEN_W'(1);
          if ((beat_q + LEN_W'(1)) == len_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (enc_vld_i) begin
          enc_cnt_d = enc_cnt_q + LEN_W'(1);
        end
        if (enc_cnt_d == exp_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    vld_pipe_d = (vld_pipe_q << 1) | RD_LAT'(issue);
  end

  // State register; reset also flushes the return-valid pipe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      init_q     <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      exp_q      <= '0;
      enc_cnt_q  <= '0;
      sel_q      <= ZS_SEL_HALF;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      init_q     <= 1'b1;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      exp_q      <= exp_d;
      enc_cnt_q  <= enc_cnt_d;
      sel_q      <= sel_d;
      done_q     <= done_d;
      err_q      <= err_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  assign ret_vld        = vld_pipe_q[RD_LAT-1];
  assign mem_rd_en_o    = issue;
  assign mem_rd_addr_o  = addr_q;
  assign group_nz_sel_o = sel_q;
  assign act_vld_o      = ret_vld;
  assign znz_vld_o      = ret_vld;
  assign act_dout_o     = ret_vld ? mem_act_rdata_i : '0;
  assign znz_dout_o     = ret_vld ? mem_znz_rdata_i : '0;
  assign done_o         = done_q;
  assign err_o          = err_q;

`ifdef ZS_SCHED_PERF_EN
  logic [CNT_W-1:0] busy_q, busy_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  // Busy counts non-idle cycles; stall counts issue cycles starved of credits.
  always_comb begin
    busy_d  = busy_q;
    stall_d = stall_q;
    if (state_q != IDLE) begin
      busy_d = busy_q + CNT_W'(1);
    end
    if ((state_q == ISSUE) && (beat_q < len_q) && need_credit && !credit_avail) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // Performance counter registers, wrapping naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q  <= '0;
      stall_q <= '0;
    end else begin
      busy_q  <= busy_d;
      stall_q <= stall_d;
    end
  end

  assign perf_busy_cnt_o  = busy_q;
  assign perf_stall_cnt_o = stall_q;
`endif

endmodule
